// File: rtl/access_arbiter.sv
// Three-master arbiter: M1 top priority, M2/M3 time-sliced in bounded slots,
// with bounded M1 pre-emption of M2/M3 and resumption of the suspended master.
module access_arbiter #(
  parameter int SLOT_CYCLES = 2,
  parameter int IT_CYCLES   = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       done,
  output logic [1:0]       accmodule,
  output logic [4:0]       mstate,
  output logic [CNT_W-1:0] nb_interrupts,
  output logic [2:0]       pending
);

  localparam int SW = $clog2(SLOT_CYCLES + 1);
  localparam int WW = $clog2(IT_CYCLES + 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_CYCLES);
  localparam logic [WW-1:0] IT_MAX   = WW'(IT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_M1, S_M2, S_M3, S_IT} state_t;

  state_t          state, state_n, susp_st, susp_st_n;
  logic [SW-1:0]   slot_cnt, slot_n, susp_slot, susp_slot_n;
  logic [WW-1:0]   win_cnt, win_n;
  logic            susp_done, susp_done_n;
  logic [2:0]      pending_n, eff, grant, ign, own_bit, susp_bit;
  logic            reselect, inc, done_now;

  function automatic state_t pick(input logic [2:0] c);
    if (c[0])      return S_M1;
    else if (c[1]) return S_M2;
    else if (c[2]) return S_M3;
    else           return S_IDLE;
  endfunction

  function automatic logic [2:0] bit_of(input state_t s);
    case (s)
      S_M1:    return 3'b001;
      S_M2:    return 3'b010;
      S_M3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    slot_n      = slot_cnt;
    win_n       = win_cnt;
    susp_st_n   = susp_st;
    susp_slot_n = susp_slot;
    susp_done_n = susp_done;
    grant       = 3'b000;
    ign         = 3'b000;
    reselect    = 1'b0;
    inc         = 1'b0;
    eff         = req | pending;
    own_bit     = bit_of(state);
    susp_bit    = bit_of(susp_st);
    done_now    = susp_done | (|(done & susp_bit));
    case (state)
      S_IDLE: begin
        state_n  = pick(eff);
        reselect = 1'b1;
      end
      S_M1: begin
        ign = 3'b001;
        if (done[0]) begin
          state_n  = pick(eff & 3'b110);
          reselect = 1'b1;
        end
      end
      S_M2, S_M3: begin
        ign = own_bit;
        // done and expiry are free points; a coincident req[0] wins there as plain M1
        if ((|(done & own_bit)) || (slot_cnt == SLOT_MAX)) begin
          state_n  = pick(eff & ~own_bit);
          reselect = 1'b1;
        end else if (req[0]) begin
          state_n     = S_IT;
          win_n       = WW'(1);
          susp_st_n   = state;
          susp_slot_n = slot_cnt;
          susp_done_n = 1'b0;
          inc         = 1'b1;
          grant       = 3'b001;
        end else begin
          slot_n = slot_cnt + SW'(1);
        end
      end
      S_IT: begin
        ign         = 3'b001;
        susp_done_n = done_now;
        if (done[0] || ((win_cnt == IT_MAX) && !req[0])) begin
          if (done_now) begin
            state_n  = pick(eff & ~susp_bit & 3'b110);
            reselect = 1'b1;
          end else begin
            state_n = susp_st;
            slot_n  = susp_slot + SW'(1);
            grant   = susp_bit;
          end
        end else if (req[0]) begin
          win_n = WW'(1);
        end else begin
          win_n = win_cnt + WW'(1);
        end
      end
      default: begin
        state_n  = S_IDLE;
      end
    endcase
    if (reselect) begin
      grant  = bit_of(state_n);
      slot_n = SW'(1);
    end
    pending_n = (pending | (req & ~ign)) & ~grant;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      slot_cnt      <= '0;
      win_cnt       <= '0;
      susp_st       <= S_IDLE;
      susp_slot     <= '0;
      susp_done     <= 1'b0;
      pending       <= 3'b000;
      nb_interrupts <= '0;
    end else begin
      state     <= state_n;
      slot_cnt  <= slot_n;
      win_cnt   <= win_n;
      susp_st   <= susp_st_n;
      susp_slot <= susp_slot_n;
      susp_done <= susp_done_n;
      pending   <= pending_n;
      if (inc && !(&nb_interrupts))
        nb_interrupts <= nb_interrupts + CNT_W'(1);
    end
  end

  always_comb begin
    accmodule = 2'b00;
    mstate    = 5'b00001;
    case (state)
      S_M1: begin accmodule = 2'b01; mstate = 5'b00010; end
      S_M2: begin accmodule = 2'b10; mstate = 5'b00100; end
      S_M3: begin accmodule = 2'b11; mstate = 5'b01000; end
      S_IT: begin accmodule = 2'b01; mstate = 5'b10000; end
      default: begin accmodule = 2'b00; mstate = 5'b00001; end
    endcase
  end

endmodule

// File: tb/tb_access_arbiter.sv
// Directed bench for access_arbiter (SLOT_CYCLES=2, IT_CYCLES=2).
module tb_access_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, done;
  logic [1:0]  accmodule;
  logic [4:0]  mstate;
  logic [15:0] nb_interrupts;
  logic [2:0]  pending;
  int checks = 0;
  int errors = 0;

  access_arbiter #(.SLOT_CYCLES(2), .IT_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .accmodule(accmodule), .mstate(mstate),
    .nb_interrupts(nb_interrupts), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] a, input logic [4:0] m,
                         input logic [15:0] n, input logic [2:0] p);
    chk({tag, ".acc"}, {14'd0, accmodule}, {14'd0, a});
    chk({tag, ".mst"}, {11'd0, mstate}, {11'd0, m});
    chk({tag, ".nb"}, nb_interrupts, n);
    chk({tag, ".pend"}, {13'd0, pending}, {13'd0, p});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    req  = 3'b000;
    done = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req = 3'b000; done = 3'b000;
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 2'b00, 5'b00001, 16'd0, 3'b000);
    reset = 1'b1;

    // M1 held until its done
    req = 3'b001; tick(); chk_all("t1.grant", 2'b01, 5'b00010, 16'd0, 3'b000);
    tick();               chk_all("t1.hold",  2'b01, 5'b00010, 16'd0, 3'b000);
    done = 3'b001; tick(); chk_all("t1.rel",  2'b00, 5'b00001, 16'd0, 3'b000);

    // M2 slot expiry, then early done
    req = 3'b010; tick(); chk_all("t2.c1", 2'b10, 5'b00100, 16'd0, 3'b000);
    tick();               chk_all("t2.c2", 2'b10, 5'b00100, 16'd0, 3'b000);
    tick();               chk_all("t2.exp", 2'b00, 5'b00001, 16'd0, 3'b000);
    req = 3'b010; tick(); chk_all("t2b.c1", 2'b10, 5'b00100, 16'd0, 3'b000);
    done = 3'b010; tick(); chk_all("t2b.done", 2'b00, 5'b00001, 16'd0, 3'b000);

    // pre-emption of M2, window of 2, resume with one remaining cycle
    req = 3'b010; tick(); chk_all("t3.m2", 2'b10, 5'b00100, 16'd0, 3'b000);
    req = 3'b001; tick(); chk_all("t3.it1", 2'b01, 5'b10000, 16'd1, 3'b000);
    tick();               chk_all("t3.it2", 2'b01, 5'b10000, 16'd1, 3'b000);
    tick();               chk_all("t3.resume", 2'b10, 5'b00100, 16'd1, 3'b000);
    tick();               chk_all("t3.end", 2'b00, 5'b00001, 16'd1, 3'b000);

    // window restart by a fresh req[0]
    req = 3'b010; tick(); chk_all("t3b.m2", 2'b10, 5'b00100, 16'd1, 3'b000);
    req = 3'b001; tick(); chk_all("t3b.it1", 2'b01, 5'b10000, 16'd2, 3'b000);
    req = 3'b001; tick(); chk_all("t3b.rst", 2'b01, 5'b10000, 16'd2, 3'b000);
    tick();               chk_all("t3b.it2", 2'b01, 5'b10000, 16'd2, 3'b000);
    tick();               chk_all("t3b.resume", 2'b10, 5'b00100, 16'd2, 3'b000);
    tick();               chk_all("t3b.end", 2'b00, 5'b00001, 16'd2, 3'b000);

    // suspended M3 releases during IT_M1 -> re-select without M1
    req = 3'b100; tick(); chk_all("t3c.m3", 2'b11, 5'b01000, 16'd2, 3'b000);
    req = 3'b001; tick(); chk_all("t3c.it1", 2'b01, 5'b10000, 16'd3, 3'b000);
    done = 3'b100; req = 3'b010; tick(); chk_all("t3c.it2", 2'b01, 5'b10000, 16'd3, 3'b010);
    tick();               chk_all("t3c.resel", 2'b10, 5'b00100, 16'd3, 3'b000);
    tick();               chk_all("t3c.m2c2", 2'b10, 5'b00100, 16'd3, 3'b000);
    tick();               chk_all("t3c.end", 2'b00, 5'b00001, 16'd3, 3'b000);

    // early IT exit on done[0]
    req = 3'b010; tick(); chk_all("t3d.m2", 2'b10, 5'b00100, 16'd3, 3'b000);
    req = 3'b001; tick(); chk_all("t3d.it1", 2'b01, 5'b10000, 16'd4, 3'b000);
    done = 3'b001; tick(); chk_all("t3d.resume", 2'b10, 5'b00100, 16'd4, 3'b000);
    tick();               chk_all("t3d.end", 2'b00, 5'b00001, 16'd4, 3'b000);

    // pending while M1 busy
    req = 3'b001; tick(); chk_all("t4.m1", 2'b01, 5'b00010, 16'd4, 3'b000);
    req = 3'b100; tick(); chk_all("t4.pend", 2'b01, 5'b00010, 16'd4, 3'b100);
    done = 3'b001; tick(); chk_all("t4.m3", 2'b11, 5'b01000, 16'd4, 3'b000);
    tick();               chk_all("t4.m3c2", 2'b11, 5'b01000, 16'd4, 3'b000);
    tick();               chk_all("t4.end", 2'b00, 5'b00001, 16'd4, 3'b000);
    req = 3'b001; tick(); chk_all("t4b.m1", 2'b01, 5'b00010, 16'd4, 3'b000);
    req = 3'b100; tick(); chk_all("t4b.pend", 2'b01, 5'b00010, 16'd4, 3'b100);
    done = 3'b001; req = 3'b010; tick(); chk_all("t4b.m2", 2'b10, 5'b00100, 16'd4, 3'b100);
    tick();               chk_all("t4b.m2c2", 2'b10, 5'b00100, 16'd4, 3'b100);
    tick();               chk_all("t4b.m3", 2'b11, 5'b01000, 16'd4, 3'b000);
    tick(); tick();       chk_all("t4b.end", 2'b00, 5'b00001, 16'd4, 3'b000);

    // all three at once
    req = 3'b111; tick(); chk_all("t5.m1", 2'b01, 5'b00010, 16'd4, 3'b110);
    done = 3'b001; tick(); chk_all("t5.m2", 2'b10, 5'b00100, 16'd4, 3'b100);
    tick();               chk_all("t5.m2c2", 2'b10, 5'b00100, 16'd4, 3'b100);
    tick();               chk_all("t5.m3", 2'b11, 5'b01000, 16'd4, 3'b000);
    tick(); tick();       chk_all("t5.end", 2'b00, 5'b00001, 16'd4, 3'b000);

    // owner done coincident with req[0]: plain M1, no count
    req = 3'b010; tick(); chk_all("t7.m2", 2'b10, 5'b00100, 16'd4, 3'b000);
    done = 3'b010; req = 3'b001; tick(); chk_all("t7.m1", 2'b01, 5'b00010, 16'd4, 3'b000);
    done = 3'b001; tick(); chk_all("t7.end", 2'b00, 5'b00001, 16'd4, 3'b000);

    // non-owner done ignored
    req = 3'b010; tick(); chk_all("t8.m2", 2'b10, 5'b00100, 16'd4, 3'b000);
    done = 3'b100; tick(); chk_all("t8.keep", 2'b10, 5'b00100, 16'd4, 3'b000);
    tick();               chk_all("t8.end", 2'b00, 5'b00001, 16'd4, 3'b000);

    // async reset in the middle of IT_M1
    req = 3'b010; tick(); chk_all("t6.m2", 2'b10, 5'b00100, 16'd4, 3'b000);
    req = 3'b001; tick(); chk_all("t6.it", 2'b01, 5'b10000, 16'd5, 3'b000);
    #2 reset = 1'b0;
    #1 chk_all("t6.async", 2'b00, 5'b00001, 16'd0, 3'b000);
    req = 3'b001;
    @(posedge clk); @(posedge clk); #1;
    chk_all("t6.held", 2'b00, 5'b00001, 16'd0, 3'b000);
    req = 3'b000; reset = 1'b1;
    tick();               chk_all("t6.idle", 2'b00, 5'b00001, 16'd0, 3'b000);
    req = 3'b001; tick(); chk_all("t6.m1", 2'b01, 5'b00010, 16'd0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
